wb_dma_copy_ctrl: RTL
=====================

Name: wb_dma_copy_ctrl

Overview:
- Wishbone block-copy sequencer that drives the currently idle DMA master port (m1) of the 16-bit Wishbone arbiter.
- Copies len 16-bit words from a source byte address to a destination byte address, in chunks of up to BURST_LEN words.
- Each chunk is read into a local buffer, then written back out.
- Configured and started from GPIO register outputs; reports busy, done and error status back to GPIO.

Parameters:
- BURST_LEN, 8, max words per read/write chunk; power of 2, range 2..16.
- TIMEOUT, 255, cycles without m_ack_i before a timeout error is declared; range 1..65535.

Ports:
- clk  in  1  system clock (125 MHz)
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle start pulse
- abort  in  1  level; aborts the transfer in progress
- src_adr  in  32  source byte address; bit 0 ignored
- dst_adr  in  32  destination byte address; bit 0 ignored
- len  in  16  transfer length in words
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag
- err_code  out  2  00 none, 01 bus error, 10 timeout, 11 abort
- words_done  out  16  words written so far in the current transfer
- m_adr_o  out  32  Wishbone address
- m_dat_o  out  16  write data
- m_dat_i  in  16  read data
- m_sel_o  out  2  byte selects
- m_we_o  out  1  write enable
- m_cyc_o  out  1  bus cycle
- m_stb_o  out  1  strobe
- m_cti_o  out  3  cycle type identifier
- m_ack_i  in  1  acknowledge
- m_err_i  in  1  bus error
- m_rty_i  in  1  retry

Behaviour:
- Reset values: all outputs 0 except m_sel_o = 2'b11. Buffer contents are don't-care.
- States: IDLE, RD, GAP, WR, DONE, ERR.
- IDLE:
  - start=1 latches src_adr, dst_adr (bit 0 forced to 0) and len; clears err, err_code and words_done.
  - If len != 0: go to RD. m_cyc_o/m_stb_o rise on the next cycle (start at cycle 0 -> stb at cycle 1).
  - If len == 0: go to DONE, no bus activity.
  - start while busy is ignored.
- chunk = min(BURST_LEN, remaining), computed on entry to each RD.
- RD:
  - Drives cyc=stb=1, we=0, adr=cur_src.
  - cti=3'b010 on every beat except the final beat of the chunk, which uses 3'b111. Single-word chunk: cti=3'b111.
  - Each m_ack_i: buf[idx] <= m_dat_i; cur_src += 2; idx++.
  - After chunk acks: go to GAP with target WR.
- GAP:
  - One cycle with cyc=stb=0. The arbiter may re-arbitrate here.
  - Then go to the target state; idx resets to 0.
- WR:
  - Same as RD but we=1, adr=cur_dst, m_dat_o=buf[idx].
  - Each ack: cur_dst += 2; words_done++.
  - After chunk acks: remaining -= chunk. If remaining == 0 go to DONE, else go to GAP with target RD.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy is 1 in RD, GAP and WR, and 0 in IDLE, DONE and ERR.
- m_rty_i: the current beat is not advanced; stb stays high and the same address/data are re-presented. It does not reset the timeout counter.
- Timeout: counter cleared on every ack and on entry to RD/WR; increments while stb=1. Reaching TIMEOUT -> ERR with code 10.
- m_err_i -> ERR with code 01; the beat is not counted.
- abort=1 in RD/GAP/WR -> ERR with code 11 on the next cycle. abort in IDLE has no effect.
- Priority in the same cycle: abort > m_err_i > m_ack_i > m_rty_i.
- ERR:
  - cyc=stb=0 in the same cycle ERR is entered (registered outputs: deasserted on the clock after the event).
  - err=1, no done pulse. Go to IDLE after one cycle; err/err_code hold until the next accepted start.
- Address arithmetic wraps modulo 2^32.
- len=65535 is valid. words_done counts up to len.
- rstn asserted mid-transfer drops cyc/stb immediately (asynchronous) and returns to IDLE.

Test Plan:
- Copy: len=3, src=0x1000, dst=0x1100, slave acks every cycle. Expect reads at 0x1000/2/4 with cti 010,010,111, one GAP cycle, then writes of the same data to 0x1100/2/4. done pulses once; words_done=3.
- Chunking: BURST_LEN=8, len=20. Expect chunks of 8, 8 and 4, with a GAP between every RD/WR phase, 40 acks total, and words_done=20 at done.
- len=0 start: done one cycle after start, m_cyc_o never asserted, err=0.
- Retry then error: m_rty_i on read beat 2 -> same address re-presented, data correct. Then m_err_i on write beat 1 -> cyc drops, err=1, err_code=01, no done, words_done=0.
- Timeout: TIMEOUT=16, slave never acks. err_code=10 after 16 strobe cycles, cyc=0. A following start with len=1 completes normally and clears err.
- Abort mid-WR after 2 acks: cyc=0 next cycle, err_code=11, words_done=2. start during busy is ignored: latched addresses are unchanged.

Source files
------------

// File: rtl/wb_dma_copy_ctrl.sv
// Wishbone block-copy sequencer driving the arbiter's DMA master port.
// Copies len words in chunks of up to BURST_LEN: read a chunk into a buffer, then write it out.
module wb_dma_copy_ctrl #(
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] src_adr,
  input  logic [31:0] dst_adr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] words_done,
  output logic [31:0] m_adr_o,
  output logic [15:0] m_dat_o,
  input  logic [15:0] m_dat_i,
  output logic [1:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic [2:0]  m_cti_o,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  input  logic        m_rty_i
);

  // state | meaning
  // IDLE  | waiting for an accepted start
  // RD    | reading the current chunk into data_buf
  // GAP   | one bus-idle cycle between phases
  // WR    | writing data_buf out to the destination
  // DONE  | one-cycle completion pulse
  // ERR   | bus error, timeout or abort recorded; bus released
  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_GAP, S_WR, S_DONE, S_ERR
  } state_t;

  localparam int          IW       = $clog2(BURST_LEN);
  localparam logic [15:0] BURST_W  = 16'(BURST_LEN);
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [31:0]   cur_src, cur_dst;
  logic [15:0]   remaining;
  logic [15:0]   chunk;
  logic [15:0]   tmo_cnt;
  logic [IW-1:0] idx;
  logic [15:0]   data_buf [BURST_LEN];
  logic          gap_to_wr;
  logic          in_bus, in_xfer, last_beat;
  logic          ev_abort, ev_berr, ev_ack, ev_tmo;

  // Retry needs no action of its own: without an ack nothing advances.
  logic unused_in;
  assign unused_in = ^{src_adr[0], dst_adr[0], m_rty_i};

  assign m_sel_o = 2'b11;

  assign chunk     = (remaining > BURST_W) ? BURST_W : remaining;
  assign last_beat = (16'(idx) == (chunk - 16'd1));

  assign in_bus  = (state == S_RD) || (state == S_WR);
  assign in_xfer = in_bus || (state == S_GAP);

  assign ev_abort = in_xfer && abort;
  assign ev_berr  = in_bus && !abort && m_err_i;
  assign ev_ack   = in_bus && !abort && !m_err_i && m_ack_i;
  assign ev_tmo   = in_bus && !abort && !m_err_i && !m_ack_i && (tmo_cnt == 16'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    m_cyc_o   = 1'b0;
    m_stb_o   = 1'b0;
    m_we_o    = 1'b0;
    m_adr_o   = '0;
    m_dat_o   = '0;
    m_cti_o   = 3'b000;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (len == 16'd0) ? S_DONE : S_RD;
      end
      S_RD: begin
        busy    = 1'b1;
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_adr_o = cur_src;
        m_cti_o = last_beat ? 3'b111 : 3'b010;
        if (ev_abort || ev_berr || ev_tmo) state_nxt = S_ERR;
        else if (ev_ack && last_beat)      state_nxt = S_GAP;
      end
      S_GAP: begin
        busy = 1'b1;
        if (ev_abort) state_nxt = S_ERR;
        else          state_nxt = gap_to_wr ? S_WR : S_RD;
      end
      S_WR: begin
        busy    = 1'b1;
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_we_o  = 1'b1;
        m_adr_o = cur_dst;
        m_dat_o = data_buf[idx];
        m_cti_o = last_beat ? 3'b111 : 3'b010;
        if (ev_abort || ev_berr || ev_tmo) state_nxt = S_ERR;
        else if (ev_ack && last_beat)      state_nxt = (remaining == chunk) ? S_DONE : S_GAP;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_src    <= '0;
      cur_dst    <= '0;
      remaining  <= '0;
      idx        <= '0;
      gap_to_wr  <= 1'b0;
      words_done <= '0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      if ((state == S_IDLE) && start) begin
        cur_src    <= {src_adr[31:1], 1'b0};
        cur_dst    <= {dst_adr[31:1], 1'b0};
        remaining  <= len;
        idx        <= '0;
        gap_to_wr  <= 1'b0;
        words_done <= '0;
        err        <= 1'b0;
        err_code   <= 2'b00;
      end
      if (state == S_GAP) idx <= '0;
      if (ev_ack) begin
        idx <= idx + IW'(1);
        if (state == S_RD) begin
          cur_src <= cur_src + 32'd2;
          if (last_beat) gap_to_wr <= 1'b1;
        end else begin
          cur_dst    <= cur_dst + 32'd2;
          words_done <= words_done + 16'd1;
          if (last_beat) begin
            remaining <= remaining - chunk;
            gap_to_wr <= 1'b0;
          end
        end
      end
      if (ev_abort) begin
        err      <= 1'b1;
        err_code <= 2'b11;
      end else if (ev_berr) begin
        err      <= 1'b1;
        err_code <= 2'b01;
      end else if (ev_tmo) begin
        err      <= 1'b1;
        err_code <= 2'b10;
      end
    end
  end

  // Down-counter reloads whenever the strobe is low or a beat is acked.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                    tmo_cnt <= TMO_LOAD;
    else if (!in_bus || ev_ack)   tmo_cnt <= TMO_LOAD;
    else if (tmo_cnt != 16'd0)    tmo_cnt <= tmo_cnt - 16'd1;
  end

  always_ff @(posedge clk) begin
    if (ev_ack && (state == S_RD)) data_buf[idx] <= m_dat_i;
  end

endmodule
